// File: rtl/gb_intf.sv
// Shared DMG I/O types and constants: controller state word and P1 register layout.
package gb_intf;

    typedef logic [7:0] cntrlr_data;

    localparam int P1_SEL_DIR = 4;
    localparam int P1_SEL_BTN = 5;

    localparam cntrlr_data CNTRLR_RELEASED = 8'hFF;

    // Selected-group nibble as the CPU sees it in P1[3:0]; 0 means pressed.
    function automatic logic [3:0] p1_nibble(input cntrlr_data d, input logic [1:0] sel);
        logic [3:0] dir_pressed;
        logic [3:0] btn_pressed;
        dir_pressed = ~{d[2], d[3], d[1], d[0]};
        btn_pressed = ~{d[4], d[5], d[6], d[7]};
        return ~(({4{~sel[0]}} & dir_pressed) | ({4{~sel[1]}} & btn_pressed));
    endfunction

endpackage

// File: rtl/gb_joypad_if.sv
// Joypad bus bundle: controller state stream in, P1 register access, interrupt out.
interface gb_joypad_if;
    import gb_intf::*;

    cntrlr_data  ctrl_data;
    logic        ctrl_valid;
    logic        ctrl_ready;
    logic        p1_wr;
    logic [7:0]  p1_wdata;
    logic [7:0]  p1_rdata;
    logic        irq_joypad;

    modport master (
        output ctrl_data, ctrl_valid, p1_wr, p1_wdata,
        input  ctrl_ready, p1_rdata, irq_joypad
    );

    modport slave (
        input  ctrl_data, ctrl_valid, p1_wr, p1_wdata,
        output ctrl_ready, p1_rdata, irq_joypad
    );

endinterface

// File: rtl/gb_joypad_debounce.sv
// Single-bit debouncer: the stable output only follows raw after it has
// differed for DEBOUNCE_CYCLES consecutive cycles.
module gb_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic stable
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= '0;
            stable <= 1'b1;
        end else if (raw == stable) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            stable <= raw;
            cnt    <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/gb_joypad.sv
// P1 (FF00) joypad register: latches controller state, debounces each key,
// exposes the selected key group and pulses an interrupt on new presses.
module gb_joypad
    import gb_intf::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input logic        clk,
    input logic        reset_n,
    gb_joypad_if.slave bus
);

    cntrlr_data  raw;
    cntrlr_data  stable;
    logic [1:0]  sel;
    logic        ready;
    logic [7:0]  rdata;
    logic        irq;
    logic [7:0]  rdata_next;
    logic        unused_wdata;

    assign unused_wdata = ^{bus.p1_wdata[7:6], bus.p1_wdata[3:0]};

    for (genvar i = 0; i < 8; i++) begin : g_bit
        gb_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk     (clk),
            .reset_n (reset_n),
            .raw     (raw[i]),
            .stable  (stable[i])
        );
    end

    assign rdata_next = {2'b11, sel, p1_nibble(stable, sel)};

    // The interrupt compares the registered nibble against the one about to
    // be loaded, so select writes that expose a held key also raise it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready <= 1'b0;
            raw   <= CNTRLR_RELEASED;
            sel   <= 2'b11;
            rdata <= 8'hFF;
            irq   <= 1'b0;
        end else begin
            ready <= 1'b1;
            if (bus.ctrl_valid && ready) begin
                raw <= bus.ctrl_data;
            end
            if (bus.p1_wr) begin
                sel <= bus.p1_wdata[P1_SEL_BTN:P1_SEL_DIR];
            end
            rdata <= rdata_next;
            irq   <= |(rdata[3:0] & ~rdata_next[3:0]);
        end
    end

    assign bus.ctrl_ready = ready;
    assign bus.p1_rdata   = rdata;
    assign bus.irq_joypad = irq;

endmodule

// File: tb/tb_gb_joypad.sv
// Scoreboard bench for gb_joypad: stimulus queues expected P1/irq events,
// a negedge monitor pops them whenever P1 changes or the interrupt fires.
module tb_gb_joypad;

    typedef struct {
        int         cyc;
        logic [7:0] rdata;
        logic       irq;
    } ev_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    ev_t  sb_q[$];
    logic [7:0] prev_rdata = 8'hFF;

    gb_joypad_if bus();

    gb_joypad #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic expectEvent(input int delay, input logic [7:0] rdata, input logic irq);
        ev_t e;
        e.cyc   = cyc + delay;
        e.rdata = rdata;
        e.irq   = irq;
        sb_q.push_back(e);
    endtask

    task automatic applyStimulus(input logic wr, input logic [7:0] wdata,
                                 input logic valid, input logic [7:0] data);
        bus.p1_wr      = wr;
        bus.p1_wdata   = wdata;
        bus.ctrl_valid = valid;
        bus.ctrl_data  = data;
        step();
        bus.p1_wr      = 1'b0;
        bus.ctrl_valid = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] exp_rdata,
                               input logic exp_irq, input logic exp_ready);
        total++;
        if ({bus.ctrl_ready, bus.irq_joypad, bus.p1_rdata} !== {exp_ready, exp_irq, exp_rdata}) begin
            bad++;
            $display("[TB] FAIL %s: got ready=%b irq=%b rdata=%h, expected ready=%b irq=%b rdata=%h",
                     name, bus.ctrl_ready, bus.irq_joypad, bus.p1_rdata, exp_ready, exp_irq, exp_rdata);
        end
    endtask

    // Any P1 change or interrupt pulse is an event that must match the queue head.
    always @(negedge clk) begin
        if (reset_n !== 1'b0 || bus.p1_rdata !== prev_rdata) begin
            if (bus.p1_rdata !== prev_rdata || bus.irq_joypad !== 1'b0) begin
                total++;
                if (sb_q.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL unexpected_event: cyc=%0d got rdata=%h irq=%b, expected no event",
                             cyc, bus.p1_rdata, bus.irq_joypad);
                end else begin
                    ev_t e;
                    e = sb_q.pop_front();
                    if (e.cyc != cyc || e.rdata !== bus.p1_rdata || e.irq !== bus.irq_joypad) begin
                        bad++;
                        $display("[TB] FAIL event: got cyc=%0d rdata=%h irq=%b, expected cyc=%0d rdata=%h irq=%b",
                                 cyc, bus.p1_rdata, bus.irq_joypad, e.cyc, e.rdata, e.irq);
                    end
                end
            end
        end
        prev_rdata = bus.p1_rdata;
    end

    initial begin
        bus.ctrl_data  = 8'hFF;
        bus.ctrl_valid = 1'b0;
        bus.p1_wr      = 1'b0;
        bus.p1_wdata   = 8'h00;

        $display("[TB] reset");
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("reset_hold", 8'hFF, 1'b0, 1'b0);
        end
        reset_n = 1'b1;
        step();
        checkOutput("reset_release", 8'hFF, 1'b0, 1'b1);
        idle(2);

        $display("[TB] select buttons, press A");
        expectEvent(2, 8'hDF, 1'b0);
        applyStimulus(1'b1, 8'h10, 1'b0, 8'hFF);
        idle(4);
        expectEvent(6, 8'hDE, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1, 8'h7F);
        idle(8);
        expectEvent(6, 8'hDF, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 8'hFF);
        idle(8);

        $display("[TB] glitch rejection on down");
        expectEvent(2, 8'hEF, 1'b0);
        applyStimulus(1'b1, 8'h20, 1'b0, 8'hFF);
        idle(4);
        applyStimulus(1'b0, 8'h00, 1'b1, 8'hFB);
        applyStimulus(1'b0, 8'h00, 1'b1, 8'hFB);
        applyStimulus(1'b0, 8'h00, 1'b1, 8'hFF);
        idle(8);
        expectEvent(6, 8'hE7, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h00, 1'b1, 8'hFB);
        idle(6);
        expectEvent(6, 8'hEF, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 8'hFF);
        idle(8);

        $display("[TB] select exposes held right");
        expectEvent(2, 8'hFF, 1'b0);
        applyStimulus(1'b1, 8'h30, 1'b0, 8'hFF);
        idle(4);
        applyStimulus(1'b0, 8'h00, 1'b1, 8'hFE);
        idle(8);
        expectEvent(2, 8'hEE, 1'b1);
        applyStimulus(1'b1, 8'h20, 1'b0, 8'hFE);
        idle(4);
        expectEvent(2, 8'hFF, 1'b0);
        applyStimulus(1'b1, 8'h30, 1'b0, 8'hFE);
        idle(4);

        $display("[TB] both groups selected");
        expectEvent(2, 8'hCE, 1'b1);
        applyStimulus(1'b1, 8'h00, 1'b0, 8'hFE);
        idle(4);
        applyStimulus(1'b0, 8'h00, 1'b1, 8'h7E);
        idle(8);
        applyStimulus(1'b0, 8'h00, 1'b1, 8'hFE);
        idle(8);
        expectEvent(6, 8'hCF, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 8'hFF);
        idle(8);

        $display("[TB] reset during debounce");
        applyStimulus(1'b0, 8'h00, 1'b1, 8'h7F);
        idle(2);
        expectEvent(0, 8'hFF, 1'b0);
        reset_n = 1'b0;
        #1;
        checkOutput("reset_async", 8'hFF, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("reset_mid_hold", 8'hFF, 1'b0, 1'b0);
        end
        reset_n = 1'b1;
        step();
        checkOutput("reset_mid_release", 8'hFF, 1'b0, 1'b1);
        idle(8);
        expectEvent(2, 8'hDF, 1'b0);
        applyStimulus(1'b1, 8'h10, 1'b0, 8'h7F);
        idle(4);
        expectEvent(6, 8'hDE, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1, 8'h7F);
        idle(10);

        while (sb_q.size() > 0) begin
            ev_t e;
            e = sb_q.pop_front();
            total++;
            bad++;
            $display("[TB] FAIL missing_event: got none, expected cyc=%0d rdata=%h irq=%b",
                     e.cyc, e.rdata, e.irq);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gb_joypad.md
# gb_joypad

Joypad register responder for the DMG I/O block. It accepts active-low button state (`cntrlr_data`) from the host-side Avalon-ST state source and debounces each button. It implements the P1 (FF00) register that the CPU writes to select a key group and reads to sample that group, and it raises the joypad interrupt request on any selected high-to-low key transition.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles a raw button bit needs before its debounced value changes. Legal range is ≥1.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `ctrl_data`  in  8  `gb_intf::cntrlr_data`, active low (0 = pressed).
- `ctrl_valid`  in  1  `ctrl_data` valid (Avalon-ST state sink).
- `ctrl_ready`  out  1  block accepts `ctrl_data`.
- `p1_wr`  in  1  CPU write strobe to P1, one cycle.
- `p1_wdata`  in  8  CPU write data. Only bits 5:4 are used.
- `p1_rdata`  out  8  current P1 read value.
- `irq_joypad`  out  1  one-cycle interrupt request pulse, destined for IF bit 4.

## Operation
- **Reset values:**
  - `ctrl_ready`=0; `p1_rdata`=8'hFF; `irq_joypad`=0.
  - Raw and debounced button registers are all 1 (released).
  - Select bits `sel[1:0]`=2'b11; debounce counters are 0.
- **Ingress:**
  - `ctrl_ready` goes to 1 on the first clock after reset deasserts and stays 1.
  - On `ctrl_valid && ctrl_ready`, `ctrl_data` is latched into the raw register.
  - Otherwise the raw register holds. Data presented with `ctrl_ready`=0 is ignored.
- **Debounce, per bit, independent:**
  - If raw equals debounced, the counter clears.
  - Otherwise the counter increments. When the counter reaches `DEBOUNCE_CYCLES`-1 and raw still differs, the debounced bit takes raw and the counter clears.
  - A raw bit returning to the debounced value before that point clears the counter; no change occurs.
  - With `DEBOUNCE_CYCLES`=1, the debounced bit follows raw one cycle later.
- **Select:** on `p1_wr`, `sel` <= `p1_wdata[5:4]`. Bit 4 is P14 (directions); bit 5 is P15 (buttons); both are active low.
- **Read value, next-state:**
  - Bits 7:6 = 2'b11.
  - Bits 5:4 = `sel`.
  - Bits 3:0 = ~((~sel[0] ? dir_pressed : 0) | (~sel[1] ? btn_pressed : 0)).
- **Nibble mapping** (d = debounced `cntrlr_data` bits, pressed = ~d):
  - Directions, bits 3..0 = {down, up, left, right} = {d[2], d[3], d[1], d[0]}.
  - Buttons, bits 3..0 = {start, select, B, A} = {d[4], d[5], d[6], d[7]}.
  - Both groups selected: bitwise OR of pressed.
  - Neither selected: nibble = 4'hF.
- **Interrupt:**
  - `irq_joypad` is registered. It is 1 for one cycle when any bit of the next `p1_rdata[3:0]` is 0 while the current `p1_rdata[3:0]` bit is 1.
  - This includes transitions caused by a select write that exposes an already-held key.
  - Multiple simultaneous falling bits produce a single pulse.
- **Simultaneous events:** a `p1_wr` and a debounced change in the same cycle are both applied. The combined result drives the next `p1_rdata` and the interrupt compare.
- **Reset mid-operation:** all state returns to reset values immediately. A held key then needs a fresh ingress and debounce; the first read after that shows it without spurious interrupts during reset.

## Timing
- **Write to read:** `p1_wr` sampled at edge N → `p1_rdata[5:4]` and the nibble are updated after edge N+1. `irq_joypad`, if any, is asserted for the cycle between edges N+1 and N+2.
- **Accept to interrupt:**
  - Accepted at edge A.
  - Raw visible after A.
  - Debounced updates at edge A+`DEBOUNCE_CYCLES`.
  - `p1_rdata` and `irq_joypad` update at edge A+`DEBOUNCE_CYCLES`+1.
- **Handshake:** `ctrl_ready` never deasserts after the post-reset cycle, so a new sample can be accepted every cycle.

## Structure
- Add to package `gb_intf`:
  - P1 bit-position constants: `P1_SEL_DIR`=4, `P1_SEL_BTN`=5.
  - Reset constant `CNTRLR_RELEASED` = 8'hFF of type `cntrlr_data`.
- One sub-module, `gb_debounce`: a 1-bit debouncer parameterised by `DEBOUNCE_CYCLES`, with ports clk, reset_n, raw, stable. It is instantiated 8×, one per button bit.
- Counter width is $clog2(`DEBOUNCE_CYCLES`+1).

## Test plan
- **Reset:** hold `reset_n`=0 for 3 cycles, then release → `p1_rdata`=8'hFF and `irq_joypad`=0 throughout; `ctrl_ready`=1 one cycle after release.
- **Select and A press:** write `p1_wdata`=8'h10 (buttons selected), then present `ctrl_data`=8'h7F (A pressed) for 1 cycle → `p1_rdata`=8'hDE at accept+5 cycles (default parameter), with exactly one `irq_joypad` pulse that same cycle.
- **Glitch rejection:**
  - Present `ctrl_data`=8'hFB (down) for 2 cycles, then 8'hFF → no change to `p1_rdata`=8'hEF (dir selected), no irq.
  - Hold 8'hFB ≥4 cycles → `p1_rdata`=8'hE7 and one irq.
- **Select exposes held key:** with right held (8'hFE) and `sel`=2'b11 (`p1_rdata`=8'hFF), write 8'h20 → `p1_rdata`=8'hEE next cycle, one irq. Writing 8'h30 afterwards → 8'hFF, no irq.
- **Both groups:** `sel`=2'b00, `ctrl_data`=8'h7E (A + right) → nibble 4'hE. Releasing only A keeps 4'hE; no irq on release.
- **Reset mid-debounce:** assert `reset_n`=0 two cycles after accepting 8'h7F → all outputs return to reset values. No irq is produced after release until the key is re-presented and debounced.
